// File: rtl/rr_hazard_unit_pkg.sv
// Shared pipeline definitions for the RR-stage hazard unit: rr_ctrl bit
// positions, register index width and the in-flight entry record.
package rr_hazard_unit_pkg;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned CNT_W  = 16;

    // rr_ctrl bit positions; bits 6:4 carry nothing the hazard unit needs
    localparam int unsigned CTRL_WR   = 0;
    localparam int unsigned CTRL_RD1  = 1;
    localparam int unsigned CTRL_RD2  = 2;
    localparam int unsigned CTRL_LOAD = 3;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             load;
        logic [IDX_W-1:0] dst;
    } hz_entry_t;

endpackage

// File: rtl/rr_hazard_unit_if.sv
// RR-stage hazard interface: the RR stage (master) presents the decoded
// instruction and flush; the hazard unit (slave) returns stall and debug state.
interface rr_hazard_unit_if #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = 3
);
    logic                                   flush;
    logic                                   rr_valid;
    logic [IDX_W-1:0]                       rr_src1_idx;
    logic [IDX_W-1:0]                       rr_src2_idx;
    logic [rr_hazard_unit_pkg::CTRL_W-1:0]  rr_ctrl;
    logic                                   stall;
    logic [rr_hazard_unit_pkg::CNT_W-1:0]   stall_count;
    logic [DEPTH-1:0]                       inflight_valid;

    modport master (
        output flush, rr_valid, rr_src1_idx, rr_src2_idx, rr_ctrl,
        input  stall, stall_count, inflight_valid
    );

    modport slave (
        input  flush, rr_valid, rr_src1_idx, rr_src2_idx, rr_ctrl,
        output stall, stall_count, inflight_valid
    );
endinterface

// File: rtl/rr_hazard_unit_hz_stage_entry.sv
// One in-flight pipe entry: the entry register plus the comparator that
// reports a RAW match of its destination against the RR source operands.
module hz_stage_entry
    import rr_hazard_unit_pkg::*;
#(
    parameter int unsigned IDX_W = rr_hazard_unit_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  hz_entry_t        ent_d_i,
    input  logic [IDX_W-1:0] src1_idx_i,
    input  logic [IDX_W-1:0] src2_idx_i,
    input  logic             rd1_i,
    input  logic             rd2_i,
    output hz_entry_t        ent_q_o,
    output logic             match_o
);

    hz_entry_t ent_q;

    // Entry register, synchronously cleared like the other pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d_i;
        end
    end

    // A valid writer whose destination is a source the RR instruction reads
    always_comb begin
        match_o = ent_q.valid & ent_q.wr &
                  ((rd1_i & (ent_q.dst == src1_idx_i)) |
                   (rd2_i & (ent_q.dst == src2_idx_i)));
    end

    assign ent_q_o = ent_q;

endmodule

// File: rtl/rr_hazard_unit.sv
// RR-stage RAW hazard detector. Tracks DEPTH in-flight instructions (EX..WB)
// and stalls the RR instruction while any of them still owes it a register.
// Optional feature: define RR_HAZARD_FORWARD_EN to assume full bypassing, so
// only a load sitting in EX (load-use) causes a stall.
module rr_hazard_unit
    import rr_hazard_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = rr_hazard_unit_pkg::IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    rr_hazard_unit_if.slave bus
);

    hz_entry_t        ent_d [DEPTH];
    hz_entry_t        ent_q [DEPTH];
    hz_entry_t        ent0_d;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] occ;
    logic             qual;
    logic             stall;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             unused_bits;

    // RR instruction entering EX; a stall or flush turns it into a bubble
    assign ent0_d = '{valid: bus.rr_valid & ~stall & ~bus.flush,
                      wr:    bus.rr_ctrl[CTRL_WR],
                      load:  bus.rr_ctrl[CTRL_LOAD],
                      dst:   bus.rr_src1_idx};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign ent_d[k] = ent0_d;
        end else begin : g_body
            assign ent_d[k] = ent_q[k-1];
        end

        hz_stage_entry #(
            .IDX_W (IDX_W)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .ent_d_i    (ent_d[k]),
            .src1_idx_i (bus.rr_src1_idx),
            .src2_idx_i (bus.rr_src2_idx),
            .rd1_i      (bus.rr_ctrl[CTRL_RD1]),
            .rd2_i      (bus.rr_ctrl[CTRL_RD2]),
            .ent_q_o    (ent_q[k]),
            .match_o    (match[k])
        );
    end

`ifdef RR_HAZARD_FORWARD_EN
    // Later stages are bypassed; a load in EX has no data to forward yet
    assign qual = match[0] & ent_q[0].load;
`else
    // No bypass: every stage up to WB holds back the read
    assign qual = |match;
`endif

    // Combinational stall; reset and flush both suppress it
    always_comb begin
        stall = bus.rr_valid & ~bus.flush & ~rst & qual;
    end

    // Per-stage occupancy for debug
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ[k] = ent_q[k].valid;
        end
    end

    // Saturating stall counter next state
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall          = stall;
    assign bus.stall_count    = cnt_q;
    assign bus.inflight_valid = occ;

    assign unused_bits = ^{bus.rr_ctrl[CTRL_W-1:4], ent_q[DEPTH-1], match};

endmodule

// File: tb/tb_rr_hazard_unit.sv
// Self-checking bench for rr_hazard_unit: directed scenarios plus randomized
// traffic, all checked against an issue-time based reference model.
// Honours RR_HAZARD_FORWARD_EN when defined.
module tb_rr_hazard_unit;
    import rr_hazard_unit_pkg::*;

    localparam int unsigned SAT_DEPTH = 31;
`ifdef RR_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] C_WR  = 7'b000_0001;
    localparam logic [6:0] C_RD1 = 7'b000_0010;
    localparam logic [6:0] C_RD2 = 7'b000_0100;
    localparam logic [6:0] C_LD  = 7'b000_1000;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    rr_hazard_unit_if #(.DEPTH(3), .IDX_W(3)) bus ();
    rr_hazard_unit_if #(.DEPTH(SAT_DEPTH), .IDX_W(3)) bus2 ();

    rr_hazard_unit #(.DEPTH(3), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rr_hazard_unit #(.DEPTH(SAT_DEPTH), .IDX_W(3)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: every accepted instruction is remembered with the cycle
    // it left RR; its stage is simply its age since then.
    typedef struct {
        logic [2:0]  dst;
        bit          wr;
        bit          load;
        int unsigned issue;
    } rec_t;

    rec_t        mq[$];
    int unsigned now     = 0;
    int unsigned m_count = 0;
    int          m_depth = 3;

    function automatic int stage_of(rec_t r);
        return int'(now - r.issue) - 1;
    endfunction

    function automatic bit m_stall(bit r, bit fl, bit v, logic [2:0] s1, logic [2:0] s2,
                                   logic [6:0] c);
        if (r || fl || !v) return 1'b0;
        foreach (mq[i]) begin
            int st;
            bit reads;
            st    = stage_of(mq[i]);
            reads = (c[1] && mq[i].dst == s1) || (c[2] && mq[i].dst == s2);
            if (st >= 0 && st < m_depth && mq[i].wr && reads) begin
                if (!FWD || (st == 0 && mq[i].load)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void m_update(bit r, bit fl, bit v, logic [2:0] s1, logic [6:0] c,
                                     bit st);
        if (r) begin
            mq.delete();
            m_count = 0;
        end else begin
            if (st && m_count < 65535) m_count++;
            if (v && !st && !fl) mq.push_back('{dst: s1, wr: c[0], load: c[3], issue: now});
        end
        now++;
        while (mq.size() > 0 && stage_of(mq[0]) >= m_depth) void'(mq.pop_front());
    endfunction

    function automatic logic [31:0] m_inflight();
        logic [31:0] b;
        b = '0;
        foreach (mq[i]) b[stage_of(mq[i])] = 1'b1;
        return b;
    endfunction

    // One cycle on the DEPTH=3 instance, checked against the model
    task automatic step(input bit r, input bit fl, input bit v, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [6:0] c);
        bit es;
        rst             = r;
        bus.flush       = fl;
        bus.rr_valid    = v;
        bus.rr_src1_idx = s1;
        bus.rr_src2_idx = s2;
        bus.rr_ctrl     = c;
        #1;
        es = m_stall(r, fl, v, s1, s2, c);
        n_tests++;
        if (bus.stall !== es) begin
            n_fail++;
            $display("FAIL stall @%0t: got %b expected %b", $time, bus.stall, es);
        end
        @(posedge clk);
        m_update(r, fl, v, s1, c, es);
        #1;
        n_tests++;
        if (bus.stall_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL stall_count @%0t: got %0d expected %0d", $time, bus.stall_count,
                     m_count);
        end
        n_tests++;
        if (bus.inflight_valid !== 3'(m_inflight())) begin
            n_fail++;
            $display("FAIL inflight_valid @%0t: got %b expected %b", $time,
                     bus.inflight_valid, 3'(m_inflight()));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0);
    endtask

    task automatic check_count(input string name, input int exp);
        n_tests++;
        if (bus.stall_count !== 16'(exp)) begin
            n_fail++;
            $display("FAIL %s: stall_count got %0d expected %0d", name, bus.stall_count, exp);
        end
    endtask

    task automatic test_reset();
        m_depth = 3;
        // Hazard-looking inputs while in reset must not stall
        step(1'b1, 1'b0, 1'b1, 3'd2, 3'd2, C_WR | C_RD1 | C_RD2 | C_LD);
        step(1'b1, 1'b0, 1'b1, 3'd2, 3'd2, C_WR | C_RD1 | C_RD2 | C_LD);
        check_count("reset_count", 0);
        n_tests++;
        if (bus.inflight_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_inflight: got %b expected 000", bus.inflight_valid);
        end
    endtask

    task automatic test_raw_back_to_back();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd2, 3'd0, C_WR);
        repeat (4) step(1'b0, 1'b0, 1'b1, 3'd2, 3'd0, C_RD1);
        idle();
        check_count("raw_b2b_count", FWD ? 0 : 3);
    endtask

    task automatic test_load_use();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, C_WR | C_LD);
        repeat (4) step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, C_RD1);
        idle();
        check_count("load_use_count", FWD ? 1 : 3);
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, C_WR);
        repeat (4) step(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, C_RD1);
        idle();
        check_count("alu_use_count", FWD ? 0 : 3);
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, C_WR | C_LD);
        step(1'b0, 1'b1, 1'b1, 3'd1, 3'd0, C_RD1);
        // Writer moved on to MEM; the flushed reader never entered EX
        n_tests++;
        if (bus.inflight_valid !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_inflight: got %b expected 010", bus.inflight_valid);
        end
        check_count("flush_count", 0);
        step(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, C_RD1);
        idle();
    endtask

    task automatic test_dual_match();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd3, 3'd0, C_WR);
        step(1'b0, 1'b0, 1'b1, 3'd4, 3'd0, C_WR);
        repeat (4) step(1'b0, 1'b0, 1'b1, 3'd3, 3'd4, C_RD1 | C_RD2);
        idle();
        // r4 occupies EX, MEM and WB while the reader waits; counted once per cycle
        check_count("dual_match_count", FWD ? 0 : 3);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 3'd2, 3'd0, C_WR | C_LD);
        step(1'b0, 1'b0, 1'b1, 3'd2, 3'd0, C_RD1);
        check_count("pre_reset_count", 1);
        step(1'b1, 1'b0, 1'b1, 3'd2, 3'd0, C_RD1);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_stall: got %b expected 0", bus.stall);
        end
        n_tests++;
        if (bus.inflight_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_inflight: got %b expected 000", bus.inflight_valid);
        end
        check_count("mid_reset_count", 0);
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                 3'($urandom_range(3)), 3'($urandom_range(3)), 7'($urandom));
        end
        idle();
    endtask

    // Long run on the deep instance: a self-dependent writer keeps stalling
    task automatic test_saturation();
        bit es;
        mq.delete();
        m_depth = SAT_DEPTH;
        bus2.flush       = 1'b0;
        bus2.rr_valid    = 1'b1;
        bus2.rr_src1_idx = 3'd1;
        bus2.rr_src2_idx = 3'd0;
        bus2.rr_ctrl     = C_WR | C_RD1 | C_LD;
        rst2 = 1'b1;
        @(posedge clk);
        m_update(1'b1, 1'b0, 1'b1, 3'd1, bus2.rr_ctrl, 1'b0);
        #1;
        rst2 = 1'b0;
        for (int i = 0; i < 72500; i++) begin
            es = m_stall(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, C_WR | C_RD1 | C_LD);
            @(posedge clk);
            m_update(1'b0, 1'b0, 1'b1, 3'd1, C_WR | C_RD1 | C_LD, es);
            #1;
        end
        n_tests++;
        if (bus2.stall_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL sat_count: got %0d expected %0d", bus2.stall_count, m_count);
        end
`ifndef RR_HAZARD_FORWARD_EN
        n_tests++;
        if (bus2.stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_full: got %h expected ffff", bus2.stall_count);
        end
`endif
        repeat (200) @(posedge clk);
        #1;
`ifndef RR_HAZARD_FORWARD_EN
        n_tests++;
        if (bus2.stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h expected ffff", bus2.stall_count);
        end
`endif
        bus2.rr_valid = 1'b0;
    endtask

    initial begin
        rst2             = 1'b1;
        bus2.flush       = 1'b0;
        bus2.rr_valid    = 1'b0;
        bus2.rr_src1_idx = 3'd0;
        bus2.rr_src2_idx = 3'd0;
        bus2.rr_ctrl     = 7'd0;
        test_reset();
        test_raw_back_to_back();
        test_load_use();
        test_flush();
        test_dual_match();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
